vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

VGA raster timing generator and output stage for the 640x480 display path. Produces the `col`/`row`/`valid` scan coordinates consumed by the screen generator and samples its 6-bit `rgb` reply. Drives the pin-level `vga_rgb`, `vga_hsync` and `vga_vsync` signals, with sync pulses aligned to the registered pixel data.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of hsync/vsync (0 = active-low)
- `clk  in  1`  system clock; single clock domain
- `rst_n  in  1`  reset, synchronous, active-low
- `pix_en  in  1`  pixel tick; all state advances only on cycles with `pix_en=1`
- `rgb  in  6`  pixel colour from the screen generator for the current `col`/`row`
- `col  out  10`  current horizontal position, 0..H_TOTAL-1
- `row  out  10`  current vertical position, 0..V_TOTAL-1
- `valid  out  1`  1 when `col<H_ACTIVE` and `row<V_ACTIVE`
- `frame_start  out  1`  one-cycle pulse when the raster enters (0,0)
- `vga_rgb  out  6`  registered pixel to the DAC; 0 in blanking
- `vga_hsync  out  1`  registered hsync, aligned with `vga_rgb`
- `vga_vsync  out  1`  registered vsync, aligned with `vga_rgb`
- `frame_cnt  out  16`  frame counter; present only with `VGA_FRAME_CNT_EN`

## Operation
- Totals: H_TOTAL = 640+16+96+48 = 800 and V_TOTAL = 480+10+2+33 = 525. Both counters are 10 bits wide.
- Stage 0 (scan) registers: `col`, `row`, `valid`, `hs0`, `vs0`.
  - All update together on `pix_en`.
  - Decode uses the next-state counter values, so the flags always match `col`/`row` in the same cycle.
- Counter advance:
  - On `pix_en`, `col` increments.
  - At `col=H_TOTAL-1`, `col` wraps to 0 and `row` increments.
  - At `row=V_TOTAL-1` with `col` wrapping, `row` wraps to 0.
- Sync decode, in stage 0:
  - `hs0` is asserted for `col` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - `vs0` is asserted for `row` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - Asserted level is `SYNC_POL`.
- `frame_start` pulses for exactly one `clk` cycle: the cycle whose `pix_en` moves the counters to (0,0).
- Stage 1 (output) registers update on `pix_en` as follows:
  - `vga_rgb` ← `valid ? rgb : 0`
  - `vga_hsync` ← `hs0`
  - `vga_vsync` ← `vs0`
- `rgb` is combinational from stage 0. It is sampled only while `valid=1`; any value during blanking is ignored.
- When `pix_en=0`, every register holds its value and `frame_start` is 0.

## Timing
- Reset (`rst_n=0` at a `clk` edge) sets:
  - `col=H_TOTAL-1` (799), `row=V_TOTAL-1` (524)
  - `valid=0`, `frame_start=0`, `vga_rgb=0`
  - both syncs deasserted (`!SYNC_POL`), `frame_cnt=0`
- The first `pix_en` after reset release moves the raster to (0,0) with `valid=1` and `frame_start=1`. Pixel (0,0) is therefore never lost.
- Latency: `rgb` for a given (`col`,`row`) appears on `vga_rgb` one `pix_en` tick later. Syncs carry the same one-tick delay, so pin-level timing is exact.
- Reset asserted mid-frame takes priority over `pix_en` and returns the block to the reset state on that edge. No partial line or partial pulse is emitted afterwards.
- Line period is 800 ticks; frame period is 420000 ticks. Both are constant regardless of how `pix_en` is spaced.

## Configuration
- `VGA_FRAME_CNT_EN` defined:
  - `frame_cnt` port exists.
  - It increments by 1 in the same cycle `frame_start` pulses and wraps from 65535 to 0.
  - Reset value is 0. The first frame after reset reads 1.
- `VGA_FRAME_CNT_EN` undefined:
  - `frame_cnt` port and its register are absent.
  - All other behaviour is identical.

## Test plan
- Reset and first tick:
  - Hold `rst_n=0` for 3 cycles → `col=799`, `row=524`, `valid=0`, `vga_rgb=0`, `vga_hsync=vga_vsync=1`.
  - Release, then one `pix_en` → `col=0`, `row=0`, `valid=1`, `frame_start=1`.
- Line timing:
  - `pix_en` every cycle → `valid` is high for exactly 640 consecutive ticks per line.
  - `hs0` is low for `col` 656..751.
  - `vga_hsync` low window is delayed one tick relative to `hs0`.
  - `col` wraps 799→0 with `row` +1.
- Frame timing: `vga_vsync` is low for exactly 1600 ticks starting one tick after (0,490). `frame_start` pulses once per 420000 ticks.
- RGB path and blanking:
  - `rgb=6'b110000` constant → `vga_rgb=6'b110000` one tick after each active pixel.
  - `vga_rgb=0` throughout blanking even with `rgb=6'b111111`.
- Stall:
  - `pix_en` asserted 1 cycle in 2 → counters and outputs hold on idle cycles.
  - Line takes 1600 `clk` cycles; `frame_start` width stays 1 `clk`.
- Mid-frame reset and macro:
  - Assert `rst_n=0` at (300,200) → reset values next edge; raster restarts at (0,0).
  - With `VGA_FRAME_CNT_EN`, force `frame_cnt=65535` → next `frame_start` gives `frame_cnt=0`.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator and output stage.
// Stage 0 holds the scan coordinates and sync decode; stage 1 registers the
// pin-level rgb/hsync/vsync so sync edges line up with the pixel data.
// Optional feature macro: VGA_FRAME_CNT_EN adds a 16-bit frame counter port.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   input  logic [5:0] rgb,
   output logic [9:0] col,
   output logic [9:0] row,
   output logic       valid,
   output logic       frame_start,
   output logic [5:0] vga_rgb,
   output logic       vga_hsync,
   output logic       vga_vsync
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic SYNC_ON  = SYNC_POL;
   localparam logic SYNC_OFF = ~SYNC_POL;

   // stage 0
   logic [9:0] col_q, col_d;
   logic [9:0] row_q, row_d;
   logic       valid_q, valid_d;
   logic       hs0_q, hs0_d;
   logic       vs0_q, vs0_d;
   logic       fs_q, fs_d;
   // stage 1
   logic [5:0] rgb_q;
   logic       hsync_q;
   logic       vsync_q;

   // Next raster position and its decode; flags are derived from the
   // next-state counters so they stay aligned with col/row once registered.
   always_comb begin
      col_d = col_q + 10'd1;
      row_d = row_q;
      if (col_q == H_LAST) begin
         col_d = '0;
         if (row_q == V_LAST) begin
            row_d = '0;
         end else begin
            row_d = row_q + 10'd1;
         end
      end
      valid_d = (col_d < H_ACT) && (row_d < V_ACT);
      hs0_d   = ((col_d >= HS_BEG) && (col_d < HS_END)) ? SYNC_ON : SYNC_OFF;
      vs0_d   = ((row_d >= VS_BEG) && (row_d < VS_END)) ? SYNC_ON : SYNC_OFF;
      fs_d    = (col_d == '0) && (row_d == '0);
   end

   // Scan and output pipeline; everything advances only on pixel ticks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_q   <= H_LAST;
         row_q   <= V_LAST;
         valid_q <= 1'b0;
         hs0_q   <= SYNC_OFF;
         vs0_q   <= SYNC_OFF;
         fs_q    <= 1'b0;
         rgb_q   <= '0;
         hsync_q <= SYNC_OFF;
         vsync_q <= SYNC_OFF;
      end else begin
         fs_q <= 1'b0;
         if (pix_en) begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            hs0_q   <= hs0_d;
            vs0_q   <= vs0_d;
            fs_q    <= fs_d;
            rgb_q   <= valid_q ? rgb : '0;
            hsync_q <= hs0_q;
            vsync_q <= vs0_q;
         end
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] fcnt_q;

   // Frame counter steps on the same edge that raises frame_start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fcnt_q <= '0;
      end else if (pix_en && fs_d) begin
         fcnt_q <= fcnt_q + 16'd1;
      end
   end

   assign frame_cnt = fcnt_q;
`endif

   assign col         = col_q;
   assign row         = row_q;
   assign valid       = valid_q;
   assign frame_start = fs_q;
   assign vga_rgb     = rgb_q;
   assign vga_hsync   = hsync_q;
   assign vga_vsync   = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-geometry instance and one reduced
// geometry instance (active-high syncs) so whole frames fit in a short run.
// Expected values come from arithmetic on the count of pixel ticks since reset.
module tb_vga_timing_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pix_en = 1'b0;
   logic [5:0] rgb = '0;

   logic [9:0] col_b, row_b, col_s, row_s;
   logic       valid_b, fs_b, hs_b, vs_b;
   logic       valid_s, fs_s, hs_s, vs_s;
   logic [5:0] vrgb_b, vrgb_s;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] fc_b, fc_s;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vga_timing_gen dut_b (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .rgb(rgb),
      .col(col_b), .row(row_b), .valid(valid_b), .frame_start(fs_b),
      .vga_rgb(vrgb_b), .vga_hsync(hs_b), .vga_vsync(vs_b)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(fc_b)
`endif
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(1'b1)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .rgb(rgb),
      .col(col_s), .row(row_s), .valid(valid_s), .frame_start(fs_s),
      .vga_rgb(vrgb_s), .vga_hsync(hs_s), .vga_vsync(vs_s)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(fc_s)
`endif
   );

   // geometry of each instance
   localparam int BHT = 800, BVT = 525;
   localparam int SHT = 15,  SVT = 8;

   // reference model state
   int         n = 0;          // pixel ticks since reset
   logic [5:0] e_rgb_b = '0, e_rgb_s = '0;
   logic       e_hs_b = 1'b1, e_vs_b = 1'b1;
   logic       e_hs_s = 1'b0, e_vs_s = 1'b0;
   logic       e_fs_b = 1'b0, e_fs_s = 1'b0;
   logic [15:0] e_fc_b = '0, e_fc_s = '0;

   // after n ticks the raster sits at linear position (n-1) mod frame size,
   // with the reset position being the last pixel of the frame
   function automatic int pcol(int k, int ht, int vt);
      return ((k + ht * vt - 1) % (ht * vt)) % ht;
   endfunction

   function automatic int prow(int k, int ht, int vt);
      return ((k + ht * vt - 1) % (ht * vt)) / ht;
   endfunction

   function automatic logic in_win(int v, int lo, int w);
      return (v >= lo) && (v < lo + w);
   endfunction

   function automatic logic b_valid(int k);
      return (pcol(k, BHT, BVT) < 640) && (prow(k, BHT, BVT) < 480);
   endfunction
   function automatic logic b_hs(int k);
      return in_win(pcol(k, BHT, BVT), 656, 96) ? 1'b0 : 1'b1;
   endfunction
   function automatic logic b_vs(int k);
      return in_win(prow(k, BHT, BVT), 490, 2) ? 1'b0 : 1'b1;
   endfunction
   function automatic logic s_valid(int k);
      return (pcol(k, SHT, SVT) < 8) && (prow(k, SHT, SVT) < 4);
   endfunction
   function automatic logic s_hs(int k);
      return in_win(pcol(k, SHT, SVT), 10, 3) ? 1'b1 : 1'b0;
   endfunction
   function automatic logic s_vs(int k);
      return in_win(prow(k, SHT, SVT), 5, 2) ? 1'b1 : 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s tick=%0d observed=%0h expected=%0h", tag, n, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("b_col",   16'(col_b),   16'(pcol(n, BHT, BVT)));
      chk("b_row",   16'(row_b),   16'(prow(n, BHT, BVT)));
      chk("b_valid", 16'(valid_b), 16'(b_valid(n)));
      chk("b_fs",    16'(fs_b),    16'(e_fs_b));
      chk("b_rgb",   16'(vrgb_b),  16'(e_rgb_b));
      chk("b_hsync", 16'(hs_b),    16'(e_hs_b));
      chk("b_vsync", 16'(vs_b),    16'(e_vs_b));
      chk("s_col",   16'(col_s),   16'(pcol(n, SHT, SVT)));
      chk("s_row",   16'(row_s),   16'(prow(n, SHT, SVT)));
      chk("s_valid", 16'(valid_s), 16'(s_valid(n)));
      chk("s_fs",    16'(fs_s),    16'(e_fs_s));
      chk("s_rgb",   16'(vrgb_s),  16'(e_rgb_s));
      chk("s_hsync", 16'(hs_s),    16'(e_hs_s));
      chk("s_vsync", 16'(vs_s),    16'(e_vs_s));
`ifdef VGA_FRAME_CNT_EN
      chk("b_fcnt",  fc_b, e_fc_b);
      chk("s_fcnt",  fc_s, e_fc_s);
`endif
   endtask

   // one clk cycle: drive inputs, advance the model on the edge, check after it
   task automatic step(input logic pe, input logic [5:0] d, input logic rs);
      @(negedge clk);
      pix_en = pe;
      rgb    = d;
      rst_n  = rs;
      @(posedge clk);
      if (!rs) begin
         n = 0;
         e_rgb_b = '0; e_rgb_s = '0;
         e_hs_b = 1'b1; e_vs_b = 1'b1;
         e_hs_s = 1'b0; e_vs_s = 1'b0;
         e_fs_b = 1'b0; e_fs_s = 1'b0;
         e_fc_b = '0;   e_fc_s = '0;
      end else if (pe) begin
         e_rgb_b = b_valid(n) ? d : 6'd0;
         e_rgb_s = s_valid(n) ? d : 6'd0;
         e_hs_b = b_hs(n); e_vs_b = b_vs(n);
         e_hs_s = s_hs(n); e_vs_s = s_vs(n);
         n++;
         e_fs_b = (pcol(n, BHT, BVT) == 0) && (prow(n, BHT, BVT) == 0);
         e_fs_s = (pcol(n, SHT, SVT) == 0) && (prow(n, SHT, SVT) == 0);
         if (e_fs_b) e_fc_b = e_fc_b + 16'd1;
         if (e_fs_s) e_fc_s = e_fc_s + 16'd1;
      end else begin
         e_fs_b = 1'b0;
         e_fs_s = 1'b0;
      end
      #1;
      check_all();
   endtask

   initial begin
      // reset held three cycles, pix_en toggling to show reset wins
      step(1'b1, 6'h3F, 1'b0);
      step(1'b0, 6'h3F, 1'b0);
      step(1'b1, 6'h3F, 1'b0);
      // release, idle cycle, then the first tick lands on (0,0)
      step(1'b0, 6'h15, 1'b1);
      step(1'b1, 6'b110000, 1'b1);
      // constant colour through the first line and into the next
      for (int i = 0; i < 1000; i++) step(1'b1, 6'b110000, 1'b1);
      // all-ones colour: blanking must still read zero
      for (int i = 0; i < 800; i++) step(1'b1, 6'b111111, 1'b1);
      // pix_en one cycle in two
      for (int i = 0; i < 1600; i++) step(1'((i % 2) == 0), 6'($urandom), 1'b1);
      // random tick spacing and colour
      for (int i = 0; i < 2000; i++) step(1'($urandom_range(0, 3) != 0), 6'($urandom), 1'b1);
      // mid-frame reset, then restart
      step(1'b1, 6'h2A, 1'b0);
      step(1'b1, 6'h2A, 1'b0);
      step(1'b0, 6'h00, 1'b1);
      for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 4) != 0), 6'($urandom), 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
